// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and reset constants for the mux4 round-robin arbiter.
package mux4_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam logic [NREQ-1:0]  GNT_RST = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_RST = 2'd0;
  localparam logic             E_RST   = 1'b1;
  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

  function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotate-priority picker: scans ptr+1, ptr+2, ptr+3, ptr,
// optionally skipping one excluded index.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic             excl_en_i,
  input  logic [SEL_W-1:0] excl_idx_i,
  output logic             valid_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] cand_s;

  // Walk from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = ptr_i;
    cand_s  = ptr_i;
    for (int k = 4; k >= 1; k--) begin
      cand_s = ptr_i + SEL_W'(k);
      if (req_i[cand_s] && !(excl_en_i && (cand_s == excl_idx_i))) begin
        valid_o = 1'b1;
        idx_o   = cand_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared mux4 (S, active-low E) with a hold limit.
// Optional LOCK input enabled by defining MUX4_ARB_LOCK_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [NREQ-1:0]  REQ,
`ifdef MUX4_ARB_LOCK_EN
  input  logic             LOCK,
`endif
  output logic [NREQ-1:0]  GNT,
  output logic [SEL_W-1:0] S,
  output logic             E,
  output logic             BUSY
);

  arb_state_e       state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [SEL_W-1:0] sel_q;
  logic             en_n_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] ptr_q;

  logic             pick_valid_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic             at_limit_s;
  logic             lock_s;

`ifdef MUX4_ARB_LOCK_EN
  assign lock_s = LOCK;
`else
  assign lock_s = 1'b0;
`endif

  assign at_limit_s = (cnt_q == CNT_W'(MAX_HOLD));

  // While granting, the current owner is excluded so "others pending" and the
  // forced-switch target come from the same pick.
  rr_pick4 u_pick (
    .req_i      (REQ),
    .ptr_i      (ptr_q),
    .excl_en_i  (state_q == GRANT),
    .excl_idx_i (sel_q),
    .valid_o    (pick_valid_s),
    .idx_o      (pick_idx_s)
  );

  // Arbitration FSM with registered mux controls and grant vector.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= GNT_RST;
      sel_q   <= SEL_RST;
      en_n_q  <= E_RST;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid_s) begin
            state_q <= GRANT;
            gnt_q   <= onehot4(pick_idx_s);
            sel_q   <= pick_idx_s;
            en_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_W'(1);
            ptr_q   <= pick_idx_s;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (!REQ[sel_q]) begin
            if (pick_valid_s) begin
              gnt_q <= onehot4(pick_idx_s);
              sel_q <= pick_idx_s;
              cnt_q <= CNT_W'(1);
              ptr_q <= pick_idx_s;
            end else begin
              state_q <= IDLE;
              gnt_q   <= GNT_RST;
              en_n_q  <= 1'b1;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
            end
          end else if (at_limit_s && pick_valid_s && !lock_s) begin
            gnt_q <= onehot4(pick_idx_s);
            sel_q <= pick_idx_s;
            cnt_q <= CNT_W'(1);
            ptr_q <= pick_idx_s;
          end else if (!at_limit_s) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= cnt_q;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= GNT_RST;
          sel_q   <= SEL_RST;
          en_n_q  <= E_RST;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          ptr_q   <= PTR_RST;
        end
      endcase
    end
  end

  assign GNT  = gnt_q;
  assign S    = sel_q;
  assign E    = en_n_q;
  assign BUSY = busy_q;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one mux4 datapath between four requesters. It drives the mux select S and the active-low enable E, and returns a one-hot grant to each requester. Outputs are registered, so the mux sees stable S/E for the whole grant. A hold limit bounds how long one requester keeps the path while others wait.

Parameters:
MAX_HOLD, 8, max consecutive grant cycles under contention (legal 1..255)
CNT_W, 8, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD

Ports:
CLK  input  1  single clock, rising edge
RST_N  input  1  reset, synchronous, active-low
REQ  input  4  request per requester; level, held until served
GNT  output  4  one-hot grant, registered; 0 when idle
S  output  2  mux select = index of granted requester
E  output  1  mux enable, active-low (0 = path enabled)
BUSY  output  1  1 while any grant is active

Behaviour:
- Reset (RST_N=0 at a rising edge, any state): GNT=0, S=0, E=1, BUSY=0, state IDLE, hold cnt=0, last-pointer ptr=3 (first priority goes to index 0).
- Pick rule: first set REQ bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4). On every new grant, ptr := granted index.
- States: IDLE, GRANT.
- IDLE:
  - REQ=0: stay in IDLE; outputs hold.
  - REQ!=0: at the next edge, GNT=onehot(pick), S=pick, E=0, BUSY=1, cnt=1, go to GRANT.
  - Latency REQ->GNT: 1 cycle.
- GRANT (cur = S):
  - REQ[cur]=0, others pending: switch at the next edge directly to pick. No idle cycle; E stays 0; cnt=1.
  - REQ[cur]=0, none pending: GNT=0, E=1, BUSY=0, S keeps last value, go to IDLE.
  - REQ[cur]=1, cnt<MAX_HOLD: keep grant; cnt++.
  - REQ[cur]=1, cnt==MAX_HOLD, others pending: forced switch to pick (excludes cur); cnt=1.
  - REQ[cur]=1, cnt==MAX_HOLD, none pending: keep grant; cnt saturates at MAX_HOLD.
- Invariants:
  - GNT is zero or one-hot. Never two bits.
  - GNT!=0 implies E=0, BUSY=1, and S==index(GNT).
  - E changes only on IDLE<->GRANT transitions.
- MAX_HOLD=1: under contention the grant rotates every cycle.
- A REQ that drops before being granted is never granted; there is no request latching.

Optional Feature:
MUX4_ARB_LOCK_EN
- Defined: adds input LOCK (1 bit). While GNT!=0, REQ[cur]=1 and LOCK=1, the hold limit is ignored: no forced switch, and cnt saturates at MAX_HOLD. When LOCK falls with cnt==MAX_HOLD and others pending, the switch occurs at the next edge.
- Undefined: no LOCK port; behaviour exactly as above.

Decomposition:
- Package mux4_arb_pkg holds:
  - NREQ=4 and SEL_W=2
  - state enum {IDLE, GRANT}
  - reset constants for GNT, S, E, ptr
- Sub-module rr_pick4: combinational rotate-priority picker. Inputs REQ[3:0], ptr[1:0], excl_en, excl_idx. Outputs valid and idx[1:0]. Instantiated once.

Test Plan:
1. Reset: RST_N=0 for 2 edges with REQ=4'b1111 -> GNT=0, S=0, E=1, BUSY=0. Release reset -> next edge GNT=4'b0001, S=0, E=0.
2. Single requester: REQ=4'b0100 -> 1 edge later GNT=4'b0100, S=2, E=0. REQ=0 -> next edge GNT=0, E=1, S stays 2.
3. Contention: MAX_HOLD=2, REQ=4'b1111 held -> GNT index sequence 0,0,1,1,2,2,3,3,0; E stays 0 throughout.
4. Saturation: REQ=4'b0001 held 20 cycles, MAX_HOLD=8 -> GNT=4'b0001 every cycle, no glitch. At cycle 20 assert REQ[2] -> next edge GNT=4'b0100, S=2.
5. Release-switch: GNT=4'b0010, REQ 4'b1010->4'b1000 -> next edge GNT=4'b1000, S=3, E=0, no idle cycle.
6. Mid-grant reset, plus LOCK under MUX4_ARB_LOCK_EN:
   - Mid-grant: RST_N=0 one edge while GNT=4'b1000 -> reset values. Next grant with REQ=4'b1001 goes to index 0.
   - LOCK: LOCK=1 with REQ=4'b0011, MAX_HOLD=2 -> GNT=4'b0001 for 10 cycles. LOCK=0 -> next edge GNT=4'b0010.
